// File: rtl/gpio_avmm_slave.sv
// GPIO peripheral on an Avalon-MM responder port: output/direction registers, synchronised
// inputs with rising-edge capture, write-1-to-clear pending bits and a masked level interrupt.
module gpio_avmm_slave #(
  parameter int GPIO_W = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [GPIO_W-1:0] gpio_gpi,
  output logic [GPIO_W-1:0] gpio_gpo,
  output logic [GPIO_W-1:0] gpio_gpd,
  output logic              irq
);

  typedef enum logic [2:0] {
    ADDR_GPI     = 3'd0,
    ADDR_GPO     = 3'd1,
    ADDR_GPD     = 3'd2,
    ADDR_IRQ_EN  = 3'd3,
    ADDR_PEND    = 3'd4,
    ADDR_GPO_SET = 3'd5,
    ADDR_GPO_CLR = 3'd6,
    ADDR_RSVD    = 3'd7
  } reg_addr_e;

  reg_addr_e        addr;
  logic [GPIO_W-1:0] wd;
  logic [GPIO_W-1:0] gpo, gpd, irq_en, pend;
  logic [GPIO_W-1:0] s1, s2, s3;
  logic [GPIO_W-1:0] rise, w1c_mask, gpo_next;
  logic [1:0]        prime_cnt;
  logic              primed;
  logic [31:0]       rd_value;
  logic              do_read;
  logic              unused_wd;

  assign addr      = reg_addr_e'(avs_address);
  assign wd        = avs_writedata[GPIO_W-1:0];
  assign unused_wd = ^avs_writedata;

  // A simultaneous write wins; the read is dropped and produces no readdatavalid.
  assign do_read = avs_read & ~avs_write;

  // The counter keeps the first edge after reset from looking like a rise for pads held high.
  assign primed = (prime_cnt == 2'd3);
  assign rise   = s2 & ~s3 & {GPIO_W{primed}};

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    gpo_next = gpo;
    w1c_mask = '0;
    if (avs_write) begin
      case (addr)
        ADDR_GPO:     gpo_next = wd;
        ADDR_GPO_SET: gpo_next = gpo | wd;
        ADDR_GPO_CLR: gpo_next = gpo & ~wd;
        ADDR_PEND:    w1c_mask = wd;
        default:      gpo_next = gpo;
      endcase
    end
  end

  always_comb begin
    rd_value = '0;
    case (addr)
      ADDR_GPI:    rd_value[GPIO_W-1:0] = s2;
      ADDR_GPO:    rd_value[GPIO_W-1:0] = gpo;
      ADDR_GPD:    rd_value[GPIO_W-1:0] = gpd;
      ADDR_IRQ_EN: rd_value[GPIO_W-1:0] = irq_en;
      ADDR_PEND:   rd_value[GPIO_W-1:0] = pend;
      default:     rd_value = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      prime_cnt <= '0;
    end else begin
      s1 <= gpio_gpi;
      s2 <= s1;
      s3 <= s2;
      if (!primed) prime_cnt <= prime_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      gpo    <= '0;
      gpd    <= '0;
      irq_en <= '0;
      pend   <= '0;
    end else begin
      gpo  <= gpo_next;
      pend <= (pend & ~w1c_mask) | rise;
      if (avs_write && addr == ADDR_GPD)    gpd    <= wd;
      if (avs_write && addr == ADDR_IRQ_EN) irq_en <= wd;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= do_read;
      if (do_read) avs_readdata <= rd_value;
    end
  end

  assign gpio_gpo = gpo;
  assign gpio_gpd = gpd;
  assign irq      = |(pend & irq_en);

endmodule

// File: tb/tb_gpio_avmm_slave.sv
// Self-checking bench for gpio_avmm_slave: read expectations go into a queue when a read is
// issued and are compared when readdatavalid appears; pin-level values are checked directly.
module tb_gpio_avmm_slave;

  localparam int GPIO_W = 8;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic [2:0]        avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic [GPIO_W-1:0] gpio_gpi;
  logic [GPIO_W-1:0] gpio_gpo;
  logic [GPIO_W-1:0] gpio_gpd;
  logic              irq;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  gpio_avmm_slave #(.GPIO_W(GPIO_W)) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .gpio_gpi          (gpio_gpi),
    .gpio_gpo          (gpio_gpo),
    .gpio_gpd          (gpio_gpd),
    .irq               (irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
    avs_address = a;
    avs_read    = 1'b1;
    exp_q.push_back(exp);
    tick();
    avs_read    = 1'b0;
  endtask

  // Scoreboard consumer: readdatavalid is stable across the negative edge.
  always @(negedge clk_clk) begin
    if (avs_readdatavalid) begin
      if (exp_q.size() == 0) check("rdv_unexpected", {31'b0, avs_readdatavalid}, 32'd0);
      else                   check("readdata", avs_readdata, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset_n = 1'b0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    gpio_gpi      = 8'hFF;
    #23;
    check("rst_rdv", {31'b0, avs_readdatavalid}, 32'd0);
    reset_reset_n = 1'b1;

    // Pads high across reset release must not create a pending edge.
    tick(10);
    check("rst_gpo", {24'b0, gpio_gpo}, 32'h0);
    check("rst_gpd", {24'b0, gpio_gpd}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    bus_read(3'd4, 32'h0);
    bus_read(3'd0, 32'hFF);
    bus_read(3'd3, 32'h0);

    bus_write(3'd1, 32'hFFFF_FFA5);
    check("gpo_pin", {24'b0, gpio_gpo}, 32'hA5);
    bus_write(3'd2, 32'h0000_000F);
    check("gpd_pin", {24'b0, gpio_gpd}, 32'h0F);
    bus_read(3'd1, 32'hA5);
    bus_read(3'd2, 32'h0F);
    check("rdv_pulse", {31'b0, avs_readdatavalid}, 32'd1);
    tick();
    check("rdv_low", {31'b0, avs_readdatavalid}, 32'd0);
    check("readdata_hold", avs_readdata, 32'h0F);

    bus_write(3'd5, 32'h02);
    check("gpo_set", {24'b0, gpio_gpo}, 32'hA7);
    bus_write(3'd6, 32'h81);
    check("gpo_clr", {24'b0, gpio_gpo}, 32'h26);
    bus_write(3'd7, 32'hFF);
    bus_write(3'd0, 32'h55);
    bus_read(3'd1, 32'h26);
    bus_read(3'd5, 32'h0);
    bus_read(3'd6, 32'h0);
    bus_read(3'd7, 32'h0);
    bus_read(3'd0, 32'hFF);

    // Rising edge on bit 4 with its interrupt enabled: irq on the third edge after the change.
    gpio_gpi = 8'h00;
    tick(5);
    bus_write(3'd4, 32'hFF);
    bus_write(3'd3, 32'h10);
    bus_read(3'd4, 32'h0);
    gpio_gpi = 8'h10;
    tick();
    check("irq_edge1", {31'b0, irq}, 32'd0);
    tick();
    check("irq_edge2", {31'b0, irq}, 32'd0);
    tick();
    check("irq_edge3", {31'b0, irq}, 32'd1);
    bus_read(3'd0, 32'h10);
    bus_read(3'd4, 32'h10);
    bus_write(3'd3, 32'h00);
    check("irq_masked", {31'b0, irq}, 32'd0);
    bus_write(3'd3, 32'h10);
    check("irq_unmasked", {31'b0, irq}, 32'd1);

    // Clear, then a masked bit still latches pending without raising irq.
    bus_write(3'd4, 32'h10);
    check("irq_w1c", {31'b0, irq}, 32'd0);
    gpio_gpi = 8'h30;
    tick(4);
    check("irq_bit5_masked", {31'b0, irq}, 32'd0);
    bus_read(3'd4, 32'h20);
    bus_write(3'd4, 32'h20);
    bus_read(3'd4, 32'h0);

    // Set pend[4], then collide a fresh rise with its W1C: the edge wins.
    gpio_gpi = 8'h20;
    tick(4);
    gpio_gpi = 8'h30;
    tick(4);
    check("irq_pend4", {31'b0, irq}, 32'd1);
    gpio_gpi = 8'h20;
    tick(4);
    gpio_gpi = 8'h30;
    tick(2);
    bus_write(3'd4, 32'h10);
    check("irq_edge_wins", {31'b0, irq}, 32'd1);
    bus_read(3'd4, 32'h10);
    bus_write(3'd4, 32'h10);
    check("irq_w1c_alone", {31'b0, irq}, 32'd0);
    bus_read(3'd4, 32'h0);

    // Read and write in the same cycle: write lands, no read response.
    avs_address   = 3'd1;
    avs_writedata = 32'h11;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    tick();
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    check("rw_gpo", {24'b0, gpio_gpo}, 32'h11);
    check("rw_no_rdv", {31'b0, avs_readdatavalid}, 32'd0);
    tick();

    // Reset asserted while a read response is on the bus.
    gpio_gpi = 8'h20;
    tick(4);
    gpio_gpi = 8'h30;
    tick(4);
    check("pre_rst_irq", {31'b0, irq}, 32'd1);
    avs_address = 3'd1;
    avs_read    = 1'b1;
    @(posedge clk_clk);
    #2;
    avs_read = 1'b0;
    check("pre_rst_rdv", {31'b0, avs_readdatavalid}, 32'd1);
    check("pre_rst_data", avs_readdata, 32'h11);
    reset_reset_n = 1'b0;
    #1;
    check("async_rdv", {31'b0, avs_readdatavalid}, 32'd0);
    check("async_gpo", {24'b0, gpio_gpo}, 32'h0);
    check("async_irq", {31'b0, irq}, 32'd0);
    check("async_readdata", avs_readdata, 32'h0);
    #10;
    reset_reset_n = 1'b1;
    tick(6);
    bus_read(3'd4, 32'h0);
    bus_read(3'd3, 32'h0);
    bus_read(3'd1, 32'h0);
    bus_read(3'd0, 32'h30);
    check("post_rst_irq", {31'b0, irq}, 32'd0);

    tick(3);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
